video_timing_gen: RTL and testbench

Free-running raster timing generator for the HDMI output path, default 1280x720@60 at a 74.25 MHz pixel clock. Produces `hsync`, `vsync`, `active_video` and a one-cycle `fsync` pulse, plus the raster position. It drives the AXI-Stream-to-video bridge directly: `active_video` gates stream consumption, and the bridge locks to the rising edge of `fsync`.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_timing_gen_if.sv | 15 +
 rtl/video_timing_gen.sv | 139 +++++++++++++
 tb/tb_video_timing_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants, sync polarities and generator state type.
// Also used by the AXI-Stream-to-video bridge bench.
package video_timing_pkg;

  localparam int VTG_H_ACTIVE = 1280;
  localparam int VTG_H_FP     = 110;
  localparam int VTG_H_SYNC   = 40;
  localparam int VTG_H_BP     = 220;
  localparam int VTG_H_TOTAL  = VTG_H_ACTIVE + VTG_H_FP + VTG_H_SYNC + VTG_H_BP;

  localparam int VTG_V_ACTIVE = 720;
  localparam int VTG_V_FP     = 5;
  localparam int VTG_V_SYNC   = 5;
  localparam int VTG_V_BP     = 20;
  localparam int VTG_V_TOTAL  = VTG_V_ACTIVE + VTG_V_FP + VTG_V_SYNC + VTG_V_BP;

  localparam int VTG_CNT_W = 12;

  localparam bit VTG_HSYNC_POL = 1'b1;
  localparam bit VTG_VSYNC_POL = 1'b1;

  typedef enum logic {
    VTG_HOLD = 1'b0,
    VTG_RUN  = 1'b1
  } vtg_state_e;

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the generator to the video bridge.
// Every signal is a registered level; there is no valid/ready pair because the raster never stalls.
interface video_timing_gen_if #(
  parameter int CNT_W = 12
);
  logic             hsync;
  logic             vsync;
  logic             active_video;
  logic             fsync;
  logic [CNT_W-1:0] h_pos;
  logic [CNT_W-1:0] v_pos;

  modport master (output hsync, vsync, active_video, fsync, h_pos, v_pos);
  modport slave  (input  hsync, vsync, active_video, fsync, h_pos, v_pos);
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator; all outputs registered one cycle behind the counters.
// Optional VTG_GEN_HOLD_EN adds gen_en: the frame in flight completes, then the raster parks at (0,0).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VTG_H_ACTIVE,
  parameter int H_FP       = VTG_H_FP,
  parameter int H_SYNC     = VTG_H_SYNC,
  parameter int H_BP       = VTG_H_BP,
  parameter int V_ACTIVE   = VTG_V_ACTIVE,
  parameter int V_FP       = VTG_V_FP,
  parameter int V_SYNC     = VTG_V_SYNC,
  parameter int V_BP       = VTG_V_BP,
  parameter bit HSYNC_POL  = VTG_HSYNC_POL,
  parameter bit VSYNC_POL  = VTG_VSYNC_POL,
  parameter int FSYNC_LINE = V_ACTIVE + V_FP + V_SYNC + V_BP - 1,
  parameter int CNT_W      = VTG_CNT_W
) (
  input  logic               video_clk,
  input  logic               resetn,
`ifdef VTG_GEN_HOLD_EN
  input  logic               gen_en,
  output vtg_state_e         dbg_state,
`endif
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] FS_LINE  = CNT_W'(FSYNC_LINE);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end
  if (FSYNC_LINE < 0 || FSYNC_LINE >= V_TOTAL) begin : g_bad_fsync
    $error("video_timing_gen: FSYNC_LINE must lie inside the frame");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             count_en;
  logic             frame_end;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

`ifdef VTG_GEN_HOLD_EN
  vtg_state_e state;
  vtg_state_e state_nxt;

  always_ff @(posedge video_clk) begin
    if (!resetn) state <= VTG_HOLD;
    else         state <= state_nxt;
  end

  // gen_en is only acted on at the frame wrap, so a mid-frame glitch is ignored.
  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    case (state)
      VTG_HOLD: begin
        if (gen_en) begin
          count_en  = 1'b1;
          state_nxt = VTG_RUN;
        end
      end
      VTG_RUN: begin
        count_en = 1'b1;
        if (frame_end && !gen_en) state_nxt = VTG_HOLD;
      end
      default: state_nxt = VTG_HOLD;
    endcase
  end

  assign dbg_state = state;
`else
  assign count_en = 1'b1;
`endif

  always_ff @(posedge video_clk) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (count_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
      end else begin
        h_cnt <= h_cnt + CNT_ONE;
      end
    end
  end

  logic             hsync_q;
  logic             vsync_q;
  logic             active_q;
  logic             fsync_q;
  logic [CNT_W-1:0] h_pos_q;
  logic [CNT_W-1:0] v_pos_q;

  // A parked generator presents exactly the reset values.
  always_ff @(posedge video_clk) begin
    if (!resetn || !count_en) begin
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      active_q <= 1'b0;
      fsync_q  <= 1'b0;
      h_pos_q  <= '0;
      v_pos_q  <= '0;
    end else begin
      hsync_q  <= (h_cnt >= HS_START && h_cnt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q  <= (v_cnt >= VS_START && v_cnt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      active_q <= (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      fsync_q  <= (h_cnt == '0) && (v_cnt == FS_LINE);
      h_pos_q  <= h_cnt;
      v_pos_q  <= v_cnt;
    end
  end

  assign vid.hsync        = hsync_q;
  assign vid.vsync        = vsync_q;
  assign vid.active_video = active_q;
  assign vid.fsync        = fsync_q;
  assign vid.h_pos        = h_pos_q;
  assign vid.v_pos        = v_pos_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster; expected outputs come from a frame-phase model.
// Build with +define+VTG_GEN_HOLD_EN to also exercise the gen_en hold path.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int FS_LINE = VT - 1;
  localparam int CW = 8;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int OW = 4 + 2 * CW;
  localparam int MID_PHASE = 5 * HT + 10;

  // clock / reset
  logic video_clk = 1'b0;
  logic resetn    = 1'b0;
  logic gen_en    = 1'b1;
  always #5 video_clk = ~video_clk;

  video_timing_gen_if #(.CNT_W(CW)) vif ();
`ifdef VTG_GEN_HOLD_EN
  vtg_state_e dbg_state;
`endif

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .FSYNC_LINE(FS_LINE), .CNT_W(CW)
  ) dut (
    .video_clk(video_clk),
    .resetn(resetn),
`ifdef VTG_GEN_HOLD_EN
    .gen_en(gen_en),
    .dbg_state(dbg_state),
`endif
    .vid(vif)
  );

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: frame phase counts clocks since the start of the frame
  int phase     = 0;
  bit model_run = 1'b0;

  function automatic logic [OW-1:0] idle_word();
    return {~HP, ~VP, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}};
  endfunction

  function automatic logic [OW-1:0] phase_word(input int p);
    int  h, v;
    bit  hs, vs, act, fs;
    h   = p % HT;
    v   = p / HT;
    hs  = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
    vs  = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
    act = (h < HA) && (v < VA);
    fs  = (h == 0) && (v == FS_LINE);
    return {hs, vs, act, fs, CW'(h), CW'(v)};
  endfunction

  task automatic drive_cycle(input bit rst_n, input bit en);
    bit counting;
    @(negedge video_clk);
    resetn = rst_n;
    gen_en = en;
    if (!rst_n) begin
      exp_q.push_back(idle_word());
      phase     = 0;
      model_run = 1'b0;
    end else begin
`ifdef VTG_GEN_HOLD_EN
      counting = model_run || en;
`else
      counting = 1'b1;
`endif
      if (counting) begin
        exp_q.push_back(phase_word(phase));
        model_run = !(phase == FRAME - 1 && !en);
        phase     = (phase + 1) % FRAME;
      end else begin
        exp_q.push_back(idle_word());
      end
    end
  endtask

  task automatic settle();
    @(posedge video_clk);
    #2;
    check("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // monitor: pops one expectation per edge, gathers raster statistics
  int cyc = 0, since_rst = 0, last_fs = 0;
  bit fs_first = 1'b1, chk_period = 1'b1, stat_on = 1'b0, prev_vs = 1'b0;
  int fs_cnt = 0, act_cnt = 0, hs_cnt = 0, vs_cnt = 0, vs_bad_edge = 0;
  logic [OW-1:0] exp_w;
  logic [OW-1:0] obs_w;

  always @(posedge video_clk) begin
    #1;
    cyc++;
    if (!resetn) begin
      since_rst = 0;
      fs_first  = 1'b1;
    end else begin
      since_rst++;
    end
    obs_w = {vif.hsync, vif.vsync, vif.active_video, vif.fsync, vif.h_pos, vif.v_pos};
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      check("out", 64'(obs_w), 64'(exp_w));
    end
    if (stat_on) begin
      if (vif.fsync) fs_cnt++;
      if (vif.active_video) act_cnt++;
      if (vif.hsync == HP) hs_cnt++;
      if (vif.vsync == VP) vs_cnt++;
      if (vif.vsync != prev_vs && vif.h_pos != '0) vs_bad_edge++;
    end
    prev_vs = vif.vsync;
    if (resetn && vif.fsync) begin
      if (fs_first) check("fs_first", 64'(since_rst - 1), 64'(FS_LINE * HT));
      else if (chk_period) check("fs_period", 64'(cyc - last_fs), 64'(FRAME));
      fs_first = 1'b0;
      last_fs  = cyc;
    end
  end

  task automatic stat_clear();
    fs_cnt = 0; act_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_bad_edge = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values while held in reset
    repeat (4) drive_cycle(1'b0, 1'b1);
    settle();

    // three free-running frames from reset release
    stat_clear();
    stat_on = 1'b1;
    repeat (3 * FRAME) drive_cycle(1'b1, 1'b1);
    settle();
    stat_on = 1'b0;
    check("fs_cnt", 64'(fs_cnt), 64'd3);
    check("act_cnt", 64'(act_cnt), 64'(3 * HA * VA));
    check("hs_cnt", 64'(hs_cnt), 64'(3 * HS * VT));
    check("vs_cnt", 64'(vs_cnt), 64'(3 * VS * HT));
    check("vs_edge", 64'(vs_bad_edge), 64'd0);

    // reset pulsed mid-frame, then one more full frame
    while (phase != MID_PHASE) drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b0, 1'b1);
    repeat (FRAME + 5) drive_cycle(1'b1, 1'b1);
    settle();

`ifdef VTG_GEN_HOLD_EN
    chk_period = 1'b0;
    // short gen_en dip inside a frame has no effect
    while (phase != 2 * HT) drive_cycle(1'b1, 1'b1);
    repeat (10) drive_cycle(1'b1, 1'b0);
    repeat (FRAME) drive_cycle(1'b1, 1'b1);
    settle();
    check("state_run", 64'(dbg_state), 64'(VTG_RUN));

    // drop gen_en at line 3: frame completes, then the raster parks
    while (phase != 3 * HT) drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0);
    while (phase != 0) drive_cycle(1'b1, 1'b0);
    settle();
    stat_clear();
    stat_on = 1'b1;
    repeat (200 + $urandom_range(0, 50)) drive_cycle(1'b1, 1'b0);
    settle();
    stat_on = 1'b0;
    check("hold_act", 64'(act_cnt), 64'd0);
    check("hold_fs", 64'(fs_cnt), 64'd0);
    check("hold_hs", 64'(hs_cnt), 64'd0);
    check("state_hold", 64'(dbg_state), 64'(VTG_HOLD));

    // re-enable: (0,0) active on the next output
    repeat (FRAME + 3) drive_cycle(1'b1, 1'b1);
    settle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
